// File: rtl/aoi_exerciser.sv
// Purpose: walks all 16 {a,b,c,d} vectors into an AND-OR-INVERT block and grades its out/out_n responses.
// Latency: each vector takes SETTLE_CYCLES+1 cycles; done pulses 16*(SETTLE_CYCLES+1)+1 cycles after start is accepted.
// Backpressure: none; start is only honoured in IDLE, so requests arriving during a run or in DONE are dropped.
module aoi_exerciser #(
    parameter int SETTLE_CYCLES = 1,
    parameter int ERR_W         = 5
) (
    input  logic             clk,
    input  logic             areset_n,
    input  logic             start,
    output logic             drv_a,
    output logic             drv_b,
    output logic             drv_c,
    output logic             drv_d,
    input  logic             dut_out,
    input  logic             dut_out_n,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [3:0]       first_fail_vec,
    output logic             first_fail_valid
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        CHECK  = 3'd3,
        DONE   = 3'd4
    } state_t;

    // The settle counter is loaded on the APPLY edge, so one cycle of the
    // settle window is already spent by the time SETTLE is entered.
    localparam logic [3:0]       SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [ERR_W-1:0] ERR_MAX     = '1;
    localparam logic [ERR_W-1:0] ERR_ONE     = ERR_W'(1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] vec;
    logic [3:0] settle_cnt;
    logic [3:0] drv_q;
    logic       expected;
    logic       mismatch;

    // Golden AOI function for the vector currently being checked.
    assign expected = (vec[3] & vec[2]) | (vec[1] & vec[0]);

    // Response grading: the case match is exact in 4-state simulation, so any
    // X or Z on a response falls through to the default branch and is graded
    // as a mismatch.
    always_comb begin
        mismatch = 1'b1;
        case ({dut_out, dut_out_n})
            {expected, ~expected}: mismatch = 1'b0;
            default:               mismatch = 1'b1;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one pass through APPLY/SETTLE/CHECK per vector.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = APPLY;
                end
            end
            APPLY: begin
                if (SETTLE_CYCLES == 1) begin
                    state_nxt = CHECK;
                end else begin
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (vec == 4'd15) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = APPLY;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Vector index and settle counter; vec stops at 15 rather than wrapping.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            vec        <= 4'd0;
            settle_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        vec <= 4'd0;
                    end
                end
                APPLY: begin
                    settle_cnt <= SETTLE_LOAD;
                end
                SETTLE: begin
                    settle_cnt <= settle_cnt - 4'd1;
                end
                CHECK: begin
                    if (vec != 4'd15) begin
                        vec <= vec + 4'd1;
                    end
                end
                default: begin
                    vec <= vec;
                end
            endcase
        end
    end

    // Result registers: live error count, first failing vector, and the
    // pass verdict that only changes when a run completes.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            err_count        <= '0;
            first_fail_vec   <= 4'd0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        err_count        <= '0;
                        first_fail_vec   <= 4'd0;
                        first_fail_valid <= 1'b0;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        if (err_count != ERR_MAX) begin
                            err_count <= err_count + ERR_ONE;
                        end
                        if (!first_fail_valid) begin
                            first_fail_vec   <= vec;
                            first_fail_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    pass <= (err_count == '0);
                end
                default: begin
                    pass <= pass;
                end
            endcase
        end
    end

    // Registered stimulus and status outputs; they follow the state by one edge.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            drv_q <= 4'd0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    drv_q <= 4'd0;
                    busy  <= 1'b0;
                end
                APPLY: begin
                    drv_q <= vec;
                    busy  <= 1'b1;
                end
                DONE: begin
                    drv_q <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: begin
                    drv_q <= drv_q;
                end
            endcase
        end
    end

    assign drv_a = drv_q[3];
    assign drv_b = drv_q[2];
    assign drv_c = drv_q[1];
    assign drv_d = drv_q[0];

endmodule
